// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the uart_tx byte arbiter.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } arb_state_e;

   // Index width for an N-way requester set; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte handshake plus the uart_tx start/data/busy link.
interface uart_tx_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0][7:0]   req_data;
   logic [N_REQ-1:0]        req_last;
   logic [N_REQ-1:0]        req_ready;
   logic                    tx_start;
   logic [7:0]              tx_data;
   logic                    tx_busy;

   // Arbiter side: accepts requester bytes, drives the transmitter.
   modport master (
      input  req_valid, req_data, req_last, tx_busy,
      output req_ready, tx_start, tx_data
   );

   // Environment side: requesters and the uart_tx busy flag.
   modport slave (
      output req_valid, req_data, req_last, tx_busy,
      input  req_ready, tx_start, tx_data
   );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin pick: first eligible port at or after ptr, wrapping modulo N_REQ.
module rr_pick
   import uart_arb_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]          eligible,
   input  logic [idx_w(N_REQ)-1:0]   ptr,
   output logic [idx_w(N_REQ)-1:0]   winner,
   output logic                      any
);
   localparam int IDX_W = idx_w(N_REQ);

   // Scan farthest-first so the port closest to ptr is the last to overwrite.
   always_comb begin
      int               idx;
      logic [IDX_W-1:0] sel;
      winner = '0;
      any    = 1'b0;
      idx    = 0;
      sel    = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         sel = idx[IDX_W-1:0];
         if (eligible[sel]) begin
            winner = sel;
            any    = 1'b1;
         end
      end
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between N_REQ byte requesters: round-robin with packet lock.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int N_REQ         = 4,
   parameter int LOCK_EN       = 1,
   parameter int LOCK_TIMEOUT  = 65535,
   parameter int BUSY_WAIT_MAX = 8
) (
   input  logic                     PCLK,
   input  logic                     PRESETn,
   uart_tx_arbiter_if.master        bus,
   output logic [idx_w(N_REQ)-1:0]  grant_id,
   output logic                     active,
   output logic                     locked,
   output logic                     lock_timeout,
   output logic                     start_err
);
   localparam int IDX_W = idx_w(N_REQ);
   localparam int WC_W  = $clog2(BUSY_WAIT_MAX + 1);
   localparam int IC_W  = $clog2(LOCK_TIMEOUT + 1);

   arb_state_e       state, state_nx;
   logic [IDX_W-1:0] rr_ptr, winner;
   logic [N_REQ-1:0] eligible, req_ready;
   logic             any, accept, busy_tmo, idle_tick, idle_tmo;
   logic [WC_W-1:0]  wait_cnt;
   logic [IC_W-1:0]  idle_cnt;
   logic [7:0]       tx_data;

   function automatic logic [IDX_W-1:0] inc_mod(input logic [IDX_W-1:0] v);
      return (int'(v) == N_REQ - 1) ? '0 : v + 1'b1;
   endfunction

   // While locked only the owner may win; otherwise every valid port competes.
   always_comb begin
      eligible = bus.req_valid;
      if (locked) begin
         eligible           = '0;
         eligible[grant_id] = bus.req_valid[grant_id];
      end
   end

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .eligible (eligible),
      .ptr      (rr_ptr),
      .winner   (winner),
      .any      (any)
   );

   assign accept    = (state == S_IDLE) && any;
   assign busy_tmo  = (state == S_WAIT_BUSY) && !bus.tx_busy &&
                      (wait_cnt == WC_W'(BUSY_WAIT_MAX - 1));
   assign idle_tick = (state == S_IDLE) && locked && !bus.req_valid[grant_id];
   assign idle_tmo  = idle_tick && (idle_cnt == IC_W'(LOCK_TIMEOUT - 1));

   // Ready only in idle, one-hot on the winner, so one byte per frame.
   always_comb begin
      req_ready = '0;
      if (accept) req_ready[winner] = 1'b1;
   end

   assign bus.req_ready = req_ready;
   assign bus.tx_start  = (state == S_START);
   assign bus.tx_data   = tx_data;
   assign active        = (state != S_IDLE);

   // Next-state: idle -> start pulse -> wait busy rise -> wait busy fall.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:      if (any) state_nx = S_START;
         S_START:     state_nx = S_WAIT_BUSY;
         S_WAIT_BUSY: if (bus.tx_busy) state_nx = S_WAIT_DONE;
                      else if (busy_tmo) state_nx = S_IDLE;
         S_WAIT_DONE: if (!bus.tx_busy) state_nx = S_IDLE;
         default:     state_nx = S_IDLE;
      endcase
   end

   // State register, busy-rise watchdog and the one-cycle error pulses.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state        <= S_IDLE;
         wait_cnt     <= '0;
         start_err    <= 1'b0;
         lock_timeout <= 1'b0;
      end else begin
         state        <= state_nx;
         start_err    <= busy_tmo;
         lock_timeout <= idle_tmo;
         if (state == S_START)
            wait_cnt <= '0;
         else if ((state == S_WAIT_BUSY) && !bus.tx_busy && !busy_tmo)
            wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // Accept captures the byte and updates lock/pointer; a stalled owner loses the lock.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         tx_data  <= '0;
         grant_id <= '0;
         rr_ptr   <= '0;
         locked   <= 1'b0;
         idle_cnt <= '0;
      end else if (accept) begin
         tx_data  <= bus.req_data[winner];
         grant_id <= winner;
         idle_cnt <= '0;
         if ((LOCK_EN != 0) && !bus.req_last[winner]) begin
            locked <= 1'b1;
         end else begin
            locked <= 1'b0;
            rr_ptr <= inc_mod(winner);
         end
      end else if (idle_tmo) begin
         locked   <= 1'b0;
         rr_ptr   <= inc_mod(grant_id);
         idle_cnt <= '0;
      end else if (idle_tick) begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end
endmodule
